// File: rtl/mux_pkg.sv
// Shared defaults and helper functions for the select/register/skid datapath.
package mux_pkg;

    localparam int DATA_W     = 16;
    localparam int DEF_NUM_IN = 3;
    localparam int DEF_ERR_W  = 8;

    // Select width for n inputs; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/mux_sel_reg_if.sv
// Handshake bundle between the producer/consumer and mux_sel_reg.
interface mux_sel_reg_if import mux_pkg::*; #(
    parameter int WIDTH  = DATA_W,
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int SEL_W  = clog2(NUM_IN),
    parameter int ERR_W  = DEF_ERR_W
);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic [ERR_W-1:0]        err_count;

    modport master (
        output in_data, sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel_err, err_count
    );

    modport slave (
        input  in_data, sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel_err, err_count
    );

endinterface

// File: rtl/mux_sel_reg_skid.sv
// Output register plus one skid entry; in_ready is registered as "skid empty".
module skid_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             ready_q;
    logic             skid_valid;
    logic             skid_next;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             pop;
    logic             out_free;

    assign accept   = in_valid && ready_q;
    assign pop      = out_valid && out_ready;
    assign out_free = !out_valid || pop;
    // The registered ready comes up as soon as reset drops, so mask it while rst is high.
    assign in_ready = ready_q && !rst;

    always_comb begin
        skid_next = 1'b0;
        if (skid_valid) begin
            skid_next = !out_free;
        end else begin
            skid_next = accept && !out_free;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            ready_q    <= 1'b1;
        end else begin
            ready_q    <= !skid_next;
            skid_valid <= skid_next;
            if (skid_valid) begin
                if (out_free) begin
                    out_data  <= skid_data;
                    out_valid <= 1'b1;
                end
            end else if (accept) begin
                if (out_free) begin
                    out_data  <= in_data;
                    out_valid <= 1'b1;
                end else begin
                    skid_data <= in_data;
                end
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_sel_reg.sv
// N:1 operand select with hold-last-value on bad selects, error flag/counter,
// and a skid-buffered valid/ready output.
module mux_sel_reg import mux_pkg::*; #(
    parameter int WIDTH  = DATA_W,
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int SEL_W  = clog2(NUM_IN),
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic          clk,
    input  logic          rst,
    mux_sel_reg_if.slave  bus
);

    localparam logic [31:0] ERR_MAX = 32'((64'd1 << ERR_W) - 64'd1);

    logic [31:0]      sel_ext;
    logic             sel_ok;
    logic             accept;
    logic             ready;
    logic [WIDTH-1:0] chosen;
    logic [WIDTH-1:0] last_word;
    logic             sel_err_q;
    logic [ERR_W-1:0] err_q;

    assign sel_ext = 32'(bus.sel);
    assign sel_ok  = sel_ext < 32'(NUM_IN);
    assign accept  = bus.in_valid && ready;

    // Out-of-range selects fall through to last_word instead of indexing past in_data.
    always_comb begin
        chosen = last_word;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel_ext == 32'(i)) begin
                chosen = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_word <= '0;
            sel_err_q <= 1'b0;
            err_q     <= '0;
        end else begin
            sel_err_q <= accept && !sel_ok;
            if (accept && sel_ok) begin
                last_word <= chosen;
            end
            if (accept && !sel_ok) begin
                err_q <= ERR_W'(sat_inc(32'(err_q), ERR_MAX));
            end
        end
    end

    skid_reg #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (chosen),
        .in_valid  (bus.in_valid),
        .in_ready  (ready),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

    assign bus.in_ready  = ready;
    assign bus.sel_err   = sel_err_q;
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_mux_sel_reg.sv
// Bench for mux_sel_reg: directed scenarios plus a random run against a
// queue-based transfer model (ERR_W=2 so saturation is reachable).
module tb_mux_sel_reg;

    localparam int W  = 16;
    localparam int N  = 3;
    localparam int EW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mux_sel_reg_if #(.WIDTH(W), .NUM_IN(N), .ERR_W(EW)) bus ();

    mux_sel_reg #(.WIDTH(W), .NUM_IN(N), .ERR_W(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] vals [N];
    logic [W-1:0] mq [$];
    logic [W-1:0] m_last;
    logic [W-1:0] m_held;
    bit           m_err;
    int           m_cnt;

    task automatic drive(input bit v, input int s, input bit ordy);
        bus.in_valid  = v;
        bus.sel       = 2'(s);
        bus.out_ready = ordy;
        bus.in_data   = {vals[2], vals[1], vals[0]};
    endtask

    // The model sees the block as a FIFO of at most two words in flight.
    task automatic tick();
        bit           pp;
        bit           acc;
        int           s;
        logic [W-1:0] w;
        s = int'(bus.sel);
        if (rst) begin
            mq.delete();
            m_last = '0;
            m_held = '0;
            m_err  = 1'b0;
            m_cnt  = 0;
        end else begin
            pp    = (mq.size() > 0) && bus.out_ready;
            acc   = bus.in_valid && (mq.size() < 2);
            m_err = 1'b0;
            if (pp) m_held = mq.pop_front();
            if (acc) begin
                if (s < N) begin
                    w      = vals[s];
                    m_last = w;
                end else begin
                    w     = m_last;
                    m_err = 1'b1;
                    if (m_cnt < (1 << EW) - 1) m_cnt++;
                end
                mq.push_back(w);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=0", bus.in_ready); end
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid); end
            total++; if (bus.out_data !== 16'h0) begin bad++; $display("[TB] FAIL reset_out_data got=%h want=0000", bus.out_data); end
            total++; if (bus.err_count !== 2'd0) begin bad++; $display("[TB] FAIL reset_err_count got=%0d want=0", bus.err_count); end
        end
        rst = 1'b0;
        drive(1'b0, 0, 1'b1);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_streaming();
        logic [W-1:0] exp_w [3];
        exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333;
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i, 1'b1);
            tick();
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_valid idx=%0d got=%b want=1", i, bus.out_valid); end
            total++; if (bus.out_data !== exp_w[i]) begin bad++; $display("[TB] FAIL stream_data idx=%0d got=%h want=%h", i, bus.out_data, exp_w[i]); end
        end
        drive(1'b0, 0, 1'b1);
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_drain got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_invalid_sel();
        drive(1'b1, 1, 1'b1);
        tick();
        total++; if (bus.out_data !== 16'h2222) begin bad++; $display("[TB] FAIL inv_first got=%h want=2222", bus.out_data); end
        total++; if (bus.sel_err !== 1'b0) begin bad++; $display("[TB] FAIL inv_first_err got=%b want=0", bus.sel_err); end
        drive(1'b1, 3, 1'b1);
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h2222) begin bad++; $display("[TB] FAIL inv_hold got=%b/%h want=1/2222", bus.out_valid, bus.out_data); end
        total++; if (bus.sel_err !== 1'b1) begin bad++; $display("[TB] FAIL inv_err got=%b want=1", bus.sel_err); end
        total++; if (bus.err_count !== 2'd1) begin bad++; $display("[TB] FAIL inv_count got=%0d want=1", bus.err_count); end
        drive(1'b0, 0, 1'b1);
        tick();
        total++; if (bus.sel_err !== 1'b0) begin bad++; $display("[TB] FAIL inv_pulse_end got=%b want=0", bus.sel_err); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 0, 1'b0);
        tick();
        total++; if (bus.out_data !== 16'h1111 || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_first got=%h/%b want=1111/1", bus.out_data, bus.in_ready); end
        drive(1'b1, 1, 1'b0);
        tick();
        total++; if (bus.out_data !== 16'h1111 || bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_full got=%h/%b want=1111/0", bus.out_data, bus.in_ready); end
        drive(1'b1, 2, 1'b0);
        tick();
        total++; if (bus.out_data !== 16'h1111 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold got=%h/%b/%b want=1111/1/0", bus.out_data, bus.out_valid, bus.in_ready); end
        drive(1'b0, 0, 1'b1);
        tick();
        total++; if (bus.out_data !== 16'h2222 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release got=%h/%b/%b want=2222/1/1", bus.out_data, bus.out_valid, bus.in_ready); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_dup got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        rst = 1'b1;
        drive(1'b0, 0, 1'b1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3, 1'b1);
            tick();
            total++; if (bus.err_count !== exp_cnt[i]) begin bad++; $display("[TB] FAIL sat_count idx=%0d got=%0d want=%0d", i, bus.err_count, exp_cnt[i]); end
            total++; if (bus.sel_err !== 1'b1) begin bad++; $display("[TB] FAIL sat_err idx=%0d got=%b want=1", i, bus.sel_err); end
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0) begin bad++; $display("[TB] FAIL sat_word idx=%0d got=%b/%h want=1/0000", i, bus.out_valid, bus.out_data); end
        end
        drive(1'b0, 0, 1'b1);
        tick();
        total++; if (bus.sel_err !== 1'b0) begin bad++; $display("[TB] FAIL sat_pulse_end got=%b want=0", bus.sel_err); end
    endtask

    task automatic test_midop_reset();
        drive(1'b1, 0, 1'b0);
        tick();
        drive(1'b1, 2, 1'b0);
        tick();
        total++; if (bus.in_ready !== 1'b0 || bus.out_data !== 16'h1111) begin bad++; $display("[TB] FAIL mid_full got=%b/%h want=0/1111", bus.in_ready, bus.out_data); end
        rst = 1'b1;
        drive(1'b0, 0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 0, 1'b1);
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_after got=%b/%b want=0/1", bus.out_valid, bus.in_ready); end
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin bad++; $display("[TB] FAIL mid_stale got=%b/%h want=0/0000", bus.out_valid, bus.out_data); end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_d;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < N; k++) vals[k] = 16'($urandom);
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
            tick();
            exp_d = (mq.size() > 0) ? mq[0] : m_held;
            total++; if (bus.out_valid !== (mq.size() > 0)) begin bad++; $display("[TB] FAIL rand_valid cyc=%0d got=%b want=%b", c, bus.out_valid, mq.size() > 0); end
            total++; if (bus.out_data !== exp_d) begin bad++; $display("[TB] FAIL rand_data cyc=%0d got=%h want=%h", c, bus.out_data, exp_d); end
            total++; if (!rst && bus.in_ready !== (mq.size() < 2)) begin bad++; $display("[TB] FAIL rand_ready cyc=%0d got=%b want=%b", c, bus.in_ready, mq.size() < 2); end
            total++; if (bus.sel_err !== m_err) begin bad++; $display("[TB] FAIL rand_err cyc=%0d got=%b want=%b", c, bus.sel_err, m_err); end
            total++; if (int'(bus.err_count) != m_cnt) begin bad++; $display("[TB] FAIL rand_count cyc=%0d got=%0d want=%0d", c, bus.err_count, m_cnt); end
        end
        rst = 1'b0;
    endtask

    initial begin
        vals[0] = '0; vals[1] = '0; vals[2] = '0;
        drive(1'b1, 0, 1'b0);
        test_reset();
        test_streaming();
        test_invalid_sel();
        test_backpressure();
        test_saturation();
        test_midop_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_sel_reg.md
Name: mux_sel_reg

Overview:
- Parametrised successor to the 3:1 datapath operand mux.
- Selects one of NUM_IN WIDTH-bit inputs, registers it, and delivers it over a valid/ready handshake.
- A 2-entry skid stage gives the core datapath registered backpressure.
- An out-of-range select is an explicit "hold last value" event, not an inferred latch. It is flagged and counted.

Parameters:
WIDTH, 16, data word width in bits
NUM_IN, 3, number of data inputs (>= 2)
SEL_W, clog2(NUM_IN), select width (derived; minimum 1)
ERR_W, 8, width of saturating select-error counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_data  in  NUM_IN*WIDTH  packed inputs; input i at [i*WIDTH +: WIDTH]
sel  in  SEL_W  input select, qualified by in_valid
in_valid  in  1  sel/in_data valid this cycle
in_ready  out  1  block can accept this cycle (registered)
out_data  out  WIDTH  selected word
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
sel_err  out  1  one-cycle pulse: an accepted sel was >= NUM_IN
err_count  out  ERR_W  saturating count of accepted invalid selects

Behaviour:
- One clock domain, clk. Reset rst is synchronous and active-high.
- Reset state:
  - out_valid=0, out_data=0, sel_err=0, err_count=0.
  - Skid stage empty; last_word register=0.
  - in_ready=0 while rst=1 and =1 the first cycle after.
- Accept: in_valid && in_ready at a rising edge.
- Selected word:
  - If sel<NUM_IN: in_data[sel*WIDTH +: WIDTH].
  - Otherwise: last_word.
- last_word updates only on an accept with a valid sel.
- Pop: out_valid && out_ready.
- Update rules, per cycle:
  - skid full and (out empty or pop): out <= skid; skid empties.
  - skid empty, accept, and (out empty or pop): out <= new word.
  - Accept while out full and no pop: skid <= new word.
  - Pop with nothing to refill: out_valid <= 0. out_data holds its value (no clear).
- in_ready = !skid_valid, registered. No accept is possible while the skid is full, so data is never dropped.
- Latency: 1 cycle from accept to out_valid when the output is empty. Full throughput (1 word/cycle) while out_ready=1.
- Stability: while out_valid && !out_ready, out_data and out_valid are held.
- Ordering: strictly FIFO.
- Error handling:
  - An accept with sel>=NUM_IN sets sel_err=1 for exactly the next cycle.
  - err_count increments by 1, saturating at 2^ERR_W-1 with no wrap.
  - The held word is still delivered as a normal transfer.
  - Back-to-back invalid accepts keep sel_err high on each following cycle.
  - When NUM_IN is a power of two, invalid selects cannot occur; sel_err stays 0.
- Reset mid-operation: all in-flight words (out and skid) are discarded. State returns to reset values the cycle after rst is sampled high.
- in_data/sel are don't-care when in_valid=0 or in_ready=0.

Decomposition:
- Package mux_pkg:
  - clog2 function.
  - Default constants DATA_W=16, DEF_NUM_IN=3, DEF_ERR_W=8.
  - Saturating-increment helper function.
- One sub-module, skid_reg:
  - Parametrised WIDTH.
  - 2-entry output/skid register pair.
  - Owns the valid/ready logic.
- The top level holds the select, last_word, and error logic.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1.
  - During reset: in_ready=0, out_valid=0, out_data=0, err_count=0.
  - First cycle after: in_ready=1.
- Streaming: NUM_IN=3, inputs 0x1111/0x2222/0x3333, sel 0,1,2 on consecutive cycles, out_ready=1.
  - out_data 0x1111, 0x2222, 0x3333 on cycles 1-3, out_valid continuous.
- Invalid select: accept sel=1, then sel=3.
  - Outputs 0x2222 then 0x2222.
  - sel_err=1 for one cycle aligned with the second output.
  - err_count=1.
- Backpressure: out_ready=0, accept sel=0 then sel=1.
  - out_data=0x1111 held; in_ready=0.
  - Raise out_ready: 0x1111 then 0x2222 on consecutive cycles, in_ready returns to 1.
  - No loss, no duplication.
- Saturation: ERR_W=2, 5 invalid accepts.
  - err_count sequence 1, 2, 3, 3, 3.
  - sel_err pulses all 5 times.
- Mid-op reset: skid full, out_ready=0, assert rst 1 cycle.
  - out_valid=0 and in_ready=1 after reset.
  - Raising out_ready yields no stale word.
